// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scanner for an SPI ADC master with a one-frame address pipeline.
// Results are tagged with their true channel and held in a valid/ready register with sticky overflow.
module adc_scan_sequencer #(
  parameter int SYS_FRE    = 50_000_000,
  parameter int SPI_FRE    = 1_000_000,
  parameter int FRAME_BITS = 16,
  parameter int GAP_CYCLES = 4,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  scan_start,
  input  logic                  scan_stop,
  input  logic                  continuous,
  input  logic [7:0]            ch_enable,
  input  logic [DATA_WIDTH-1:0] data_receive,
  output logic                  spi_start,
  output logic [2:0]            addr,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [2:0]            result_ch,
  output logic                  overflow
);

  localparam int HALF         = SYS_FRE / SPI_FRE;
  localparam int FRAME_CYCLES = 2 * FRAME_BITS * HALF;
  localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ?
                                FRAME_CYCLES : GAP_CYCLES;
  localparam int CW           = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_prev_ch;
  logic                  r_prim;
  logic                  r_cont;
  logic                  r_stop;
  logic                  r_flush;
  logic                  r_spi_start;
  logic [2:0]            r_addr;
  logic                  r_busy;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_ch;
  logic                  r_ovf;

  logic [CW-1:0]         w_cnt_nxt;
  logic [2:0]            w_prev_nxt;
  logic                  w_prim_nxt;
  logic                  w_cont_nxt;
  logic                  w_stop_nxt;
  logic                  w_flush_nxt;
  logic [2:0]            w_addr_nxt;
  logic                  w_valid_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [2:0]            w_ch_nxt;
  logic                  w_ovf_nxt;

  logic                  w_any;
  logic                  w_start;
  logic                  w_frame_end;
  logic                  w_gap_end;
  logic                  w_done;
  logic                  w_push;
  logic                  w_wrap;
  logic [2:0]            w_first_ch;
  logic [2:0]            w_next_ch;
  logic [2:0]            w_idx;

  assign w_any       = |ch_enable;
  assign w_start     = (r_state == S_IDLE) && scan_start && w_any;
  assign w_frame_end = (r_state == S_FRAME) && (r_cnt == FRAME_LAST);
  assign w_gap_end   = (r_state == S_GAP) && (r_cnt == GAP_LAST);
  assign w_push      = w_gap_end && r_prim;
  assign w_wrap      = (w_next_ch <= r_addr);
  assign w_done      = !w_any ||
                       (r_cont ? (r_stop || scan_stop) : r_flush);

  // Lowest enabled bit, and nearest enabled bit after r_addr (mod 8)
  always_comb begin
    w_first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_enable[i]) w_first_ch = 3'(i);
    end
    w_idx     = 3'd0;
    w_next_ch = r_addr;
    for (int k = 7; k >= 1; k--) begin
      w_idx = r_addr + 3'(k);
      if (ch_enable[w_idx]) w_next_ch = w_idx;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_FRAME;
      S_FRAME: if (w_frame_end) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_end) begin
        w_state_nxt = w_done ? S_IDLE : S_FRAME;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt + 1'b1;
    w_prev_nxt  = r_prev_ch;
    w_prim_nxt  = r_prim;
    w_cont_nxt  = r_cont;
    w_stop_nxt  = r_stop;
    w_flush_nxt = r_flush;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_valid && !result_ready;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_ovf_nxt   = r_ovf;
    if (w_state_nxt != r_state || r_state == S_IDLE) w_cnt_nxt = '0;
    if (w_start) begin
      w_addr_nxt  = w_first_ch;
      w_prim_nxt  = 1'b0;
      w_cont_nxt  = continuous;
      w_stop_nxt  = 1'b0;
      w_flush_nxt = 1'b0;
      w_ovf_nxt   = 1'b0;
    end
    if (r_state != S_IDLE && r_cont && scan_stop) w_stop_nxt = 1'b1;
    if (w_gap_end) begin
      w_prev_nxt = r_addr;
      w_prim_nxt = 1'b1;
      if (!w_done) begin
        w_addr_nxt  = w_next_ch;
        w_flush_nxt = !r_cont && w_wrap;
      end
    end
    // The word sampled now belongs to the frame before the one just sent
    if (w_push) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = data_receive;
      w_ch_nxt    = r_prev_ch;
      if (r_valid && !result_ready) w_ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt       <= '0;
      r_prev_ch   <= 3'd0;
      r_prim      <= 1'b0;
      r_cont      <= 1'b0;
      r_stop      <= 1'b0;
      r_flush     <= 1'b0;
      r_spi_start <= 1'b0;
      r_addr      <= 3'd0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_ch        <= 3'd0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_prev_ch   <= w_prev_nxt;
      r_prim      <= w_prim_nxt;
      r_cont      <= w_cont_nxt;
      r_stop      <= w_stop_nxt;
      r_flush     <= w_flush_nxt;
      r_spi_start <= (w_state_nxt == S_FRAME);
      r_addr      <= w_addr_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_valid     <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_ch        <= w_ch_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign spi_start    = r_spi_start;
  assign addr         = r_addr;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign result_data  = r_data;
  assign result_ch    = r_ch;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: frame/result monitor, ADC word model and
// a channel-list reference for scan order and result tagging.
module tb_adc_scan_sequencer;

  localparam int DW  = 12;
  localparam int FR  = 1600;
  localparam int GP  = 4;
  localparam int PER = FR + GP;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          scan_start;
  logic          scan_stop;
  logic          continuous;
  logic [7:0]    ch_enable;
  logic [DW-1:0] data_receive;
  logic          spi_start;
  logic [2:0]    addr;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [DW-1:0] result_data;
  logic [2:0]    result_ch;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit            adc_dir;
  logic          prev_spi;
  logic [2:0]    last_addr;
  logic [DW-1:0] mon_w;

  logic [2:0]    obs_addr[$];
  logic [DW-1:0] words[$];
  logic [DW+2:0] obs_res[$];
  int            rise_cyc[$];
  logic [2:0]    exp_addr[$];
  logic [DW+2:0] exp_res[$];

  adc_scan_sequencer dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .scan_start   (scan_start),
    .scan_stop    (scan_stop),
    .continuous   (continuous),
    .ch_enable    (ch_enable),
    .data_receive (data_receive),
    .spi_start    (spi_start),
    .addr         (addr),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_ch    (result_ch),
    .overflow     (overflow)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Frame/result monitor and ADC model, sampling on the falling edge
  initial begin
    prev_spi = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && spi_start && !prev_spi) begin
        mon_w = adc_dir ? (12'h100 + {9'd0, last_addr}) : DW'($urandom);
        data_receive = mon_w;
        words.push_back(mon_w);
        obs_addr.push_back(addr);
        rise_cyc.push_back(cyc);
        last_addr = addr;
      end
      if (!sys_rst && result_valid && result_ready)
        obs_res.push_back({result_ch, result_data});
      prev_spi = spi_start;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_mon(input bit dir);
    obs_addr.delete();
    words.delete();
    obs_res.delete();
    rise_cyc.delete();
    adc_dir   = dir;
    last_addr = 3'd0;
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic c);
    ch_enable  = m;
    continuous = c;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic pulse_stop();
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
  endtask

  // Reference: enabled channels ascending, then the first again as flush
  function automatic void model_single(input logic [7:0] m);
    exp_addr.delete();
    for (int i = 0; i < 8; i++) if (m[i]) exp_addr.push_back(3'(i));
    if (exp_addr.size() > 0) exp_addr.push_back(exp_addr[0]);
  endfunction

  // Result k is the word of frame k tagged with the channel of frame k-1
  function automatic void model_results();
    exp_res.delete();
    for (int k = 1; k < exp_addr.size(); k++)
      exp_res.push_back({exp_addr[k-1], (k < words.size()) ? words[k] : {DW{1'bx}}});
  endfunction

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    n_tests++;
    if (spi_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: spi_start=%b busy=%b required 0 0", spi_start, busy);
    end
    n_tests++;
    if (addr !== 3'd0 || result_ch !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_addr: addr=%0d result_ch=%0d required 0 0", addr, result_ch);
    end
    n_tests++;
    if (result_valid !== 1'b0 || result_data !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: valid=%b data=%h ovf=%b required 0 0 0",
               result_valid, result_data, overflow);
    end
  endtask

  task automatic test_single_pass();
    int n;
    clear_mon(1'b1);
    result_ready = 1'b1;
    pulse_start(8'h05, 1'b0);
    n_tests++;
    if (busy !== 1'b1 || spi_start !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: busy=%b spi_start=%b required 1 1", busy, spi_start);
    end
    n = 0;
    while (busy && n < 10 * PER) begin tick(); n++; end
    n_tests++;
    if (n != 3 * PER) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d cycles required %0d", n, 3 * PER);
    end
    tick(); tick();
    model_single(8'h05);
    n_tests++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL single_nframes: got %0d required %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL single_addr[%0d]: got %0d required %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
    n_tests++;
    if (rise_cyc.size() < 2 || rise_cyc[1] - rise_cyc[0] != PER) begin
      n_fail++;
      $display("FAIL frame_period: got %0d required %0d",
               (rise_cyc.size() < 2) ? -1 : rise_cyc[1] - rise_cyc[0], PER);
    end
    n_tests++;
    if (obs_res.size() != 2) begin
      n_fail++;
      $display("FAIL single_nres: got %0d required 2", obs_res.size());
    end else begin
      n_tests++;
      if (obs_res[0] !== {3'd0, 12'h100} || obs_res[1] !== {3'd2, 12'h102}) begin
        n_fail++;
        $display("FAIL single_res: got %h %h required %h %h",
                 obs_res[0], obs_res[1], {3'd0, 12'h100}, {3'd2, 12'h102});
      end
    end
  endtask

  task automatic test_continuous();
    int n;
    clear_mon(1'b0);
    result_ready = 1'b1;
    pulse_start(8'h80, 1'b1);
    n = 0;
    while (obs_addr.size() < 5 && n < 8 * PER) begin tick(); n++; end
    repeat (100) tick();
    pulse_stop();
    n = 0;
    while (busy && n < 3 * PER) begin tick(); n++; end
    tick(); tick();
    n_tests++;
    if (busy !== 1'b0 || obs_addr.size() != 5) begin
      n_fail++;
      $display("FAIL cont_stop: busy=%b frames=%0d required 0 5", busy, obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== 3'd7) begin
        n_fail++;
        $display("FAIL cont_addr[%0d]: got %0d required 7", i, obs_addr[i]);
      end
    end
    n_tests++;
    if (obs_res.size() != 4) begin
      n_fail++;
      $display("FAIL cont_nres: got %0d required 4", obs_res.size());
    end
    for (int i = 0; i < obs_res.size() && i + 1 < words.size(); i++) begin
      n_tests++;
      if (obs_res[i] !== {3'd7, words[i+1]}) begin
        n_fail++;
        $display("FAIL cont_res[%0d]: got %h required %h", i, obs_res[i], {3'd7, words[i+1]});
      end
    end
  endtask

  task automatic test_zero_mask();
    bit seen;
    clear_mon(1'b0);
    seen = 1'b0;
    pulse_start(8'h00, 1'($urandom_range(0, 1)));
    repeat (20) begin
      if (busy !== 1'b0 || spi_start !== 1'b0) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL zero_mask: busy/spi_start went high, required both 0");
    end
  endtask

  task automatic test_overflow();
    int n;
    clear_mon(1'b0);
    result_ready = 1'b0;
    pulse_start(8'h03, 1'b0);
    n = 0;
    while (busy && n < 5 * PER) begin tick(); n++; end
    n_tests++;
    if (busy !== 1'b0 || result_valid !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: busy=%b valid=%b ovf=%b required 0 1 1",
               busy, result_valid, overflow);
    end
    n_tests++;
    if (words.size() < 3 || result_ch !== 3'd1 || result_data !== words[2]) begin
      n_fail++;
      $display("FAIL ovf_data: ch=%0d data=%h required ch 1 data %h",
               result_ch, result_data, (words.size() < 3) ? 12'hxxx : words[2]);
    end
    pulse_start(8'h03, 1'b0);
    n_tests++;
    if (overflow !== 1'b0 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b valid=%b required 0 1", overflow, result_valid);
    end
    result_ready = 1'b1;
    n = 0;
    while (busy && n < 5 * PER) begin tick(); n++; end
    tick(); tick();
  endtask

  task automatic test_reset_mid_gap();
    int n;
    clear_mon(1'b0);
    result_ready = 1'b1;
    pulse_start(8'h06, 1'b0);
    n = 0;
    while (obs_addr.size() < 2 && n < 3 * PER) begin tick(); n++; end
    n = 0;
    while (spi_start && n < 2 * PER) begin tick(); n++; end
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_tests++;
    if ({spi_start, busy, addr, result_valid, result_data, result_ch, overflow} !== '0) begin
      n_fail++;
      $display("FAIL rst_gap: spi=%b busy=%b addr=%0d valid=%b data=%h ch=%0d ovf=%b required all 0",
               spi_start, busy, addr, result_valid, result_data, result_ch, overflow);
    end
    repeat (3) tick();
    clear_mon(1'b0);
    pulse_start(8'h06, 1'b0);
    n = 0;
    while (busy && n < 5 * PER) begin tick(); n++; end
    tick(); tick();
    model_single(8'h06);
    model_results();
    n_tests++;
    if (obs_addr.size() != exp_addr.size() || obs_res.size() != exp_res.size()) begin
      n_fail++;
      $display("FAIL rescan_count: frames=%0d res=%0d required %0d %0d",
               obs_addr.size(), obs_res.size(), exp_addr.size(), exp_res.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL rescan_addr[%0d]: got %0d required %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
    for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
      n_tests++;
      if (obs_res[i] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL rescan_res[%0d]: got %h required %h", i, obs_res[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_mask_change();
    int n;
    clear_mon(1'b0);
    result_ready = 1'b1;
    pulse_start(8'h0F, 1'b1);
    n = 0;
    while (obs_addr.size() < 2 && n < 3 * PER) begin tick(); n++; end
    repeat (50) tick();
    ch_enable = 8'h30;
    n = 0;
    while (obs_addr.size() < 5 && n < 4 * PER) begin tick(); n++; end
    repeat (50) tick();
    pulse_stop();
    n = 0;
    while (busy && n < 3 * PER) begin tick(); n++; end
    tick(); tick();
    exp_addr = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd4};
    n_tests++;
    if (busy !== 1'b0 || obs_addr.size() != 5) begin
      n_fail++;
      $display("FAIL mask_frames: busy=%b frames=%0d required 0 5", busy, obs_addr.size());
    end
    for (int i = 0; i < 5 && i < obs_addr.size(); i++) begin
      n_tests++;
      if (obs_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL mask_addr[%0d]: got %0d required %0d", i, obs_addr[i], exp_addr[i]);
      end
    end
    for (int i = 0; i < 4 && i < obs_res.size() && i + 1 < words.size(); i++) begin
      n_tests++;
      if (obs_res[i] !== {exp_addr[i], words[i+1]}) begin
        n_fail++;
        $display("FAIL mask_res[%0d]: got %h required %h", i, obs_res[i], {exp_addr[i], words[i+1]});
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] m;
    for (int it = 0; it < 2; it++) begin
      m = 8'($urandom_range(1, 255));
      clear_mon(1'b0);
      result_ready = 1'b1;
      pulse_start(m, 1'b0);
      n = 0;
      while (busy && n < 10 * PER) begin
        result_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      result_ready = 1'b1;
      tick(); tick();
      model_single(m);
      model_results();
      n_tests++;
      if (n != exp_addr.size() * PER) begin
        n_fail++;
        $display("FAIL rand_busy_len m=%h: got %0d required %0d", m, n, exp_addr.size() * PER);
      end
      n_tests++;
      if (obs_addr.size() != exp_addr.size() || obs_res.size() != exp_res.size()) begin
        n_fail++;
        $display("FAIL rand_count m=%h: frames=%0d res=%0d required %0d %0d", m,
                 obs_addr.size(), obs_res.size(), exp_addr.size(), exp_res.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        n_tests++;
        if (obs_addr[i] !== exp_addr[i]) begin
          n_fail++;
          $display("FAIL rand_addr[%0d] m=%h: got %0d required %0d", i, m, obs_addr[i], exp_addr[i]);
        end
      end
      for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
        n_tests++;
        if (obs_res[i] !== exp_res[i]) begin
          n_fail++;
          $display("FAIL rand_res[%0d] m=%h: got %h required %h", i, m, obs_res[i], exp_res[i]);
        end
      end
      n_tests++;
      if (overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_ovf m=%h: got %b required 0", m, overflow);
      end
    end
  endtask

  initial begin
    sys_rst      = 1'b1;
    scan_start   = 1'b0;
    scan_stop    = 1'b0;
    continuous   = 1'b0;
    ch_enable    = 8'h00;
    data_receive = '0;
    result_ready = 1'b1;
    adc_dir      = 1'b0;
    last_addr    = 3'd0;
    test_reset();
    test_single_pass();
    test_continuous();
    test_zero_mask();
    test_overflow();
    test_reset_mid_gap();
    test_mask_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Round-robin channel scheduler that drives the SPI ADC master (`spi_start`, `addr`) and collects its `data_receive` words.
- Walks an 8-bit channel-enable mask and frames one conversion per enabled channel, in single-pass or continuous mode.
- Corrects for the ADC's one-frame address pipeline, so each result is tagged with the channel it belongs to.
- Presents results on a valid/ready stream to downstream logic, with a sticky overflow flag.

## Interface
- `SYS_FRE`, 50_000_000, system clock frequency in Hz.
- `SPI_FRE`, 1_000_000, SPI master toggle rate. HALF = SYS_FRE/SPI_FRE sys_clk cycles per sck half-period.
- `FRAME_BITS`, 16, sck periods per ADC frame. FRAME_CYCLES = 2*FRAME_BITS*HALF (1600 at defaults).
- `GAP_CYCLES`, 4, cycles `spi_start` is held low between frames. Minimum 2.
- `DATA_WIDTH`, 12, result width.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  synchronous active-high reset.
- `scan_start`  in  1  one-cycle start pulse. Ignored unless in IDLE.
- `scan_stop`  in  1  one-cycle stop request. Continuous mode only.
- `continuous`  in  1  1 = loop forever, 0 = single pass. Sampled on start.
- `ch_enable`  in  8  channel mask. Bit i enables channel i.
- `data_receive`  in  DATA_WIDTH  word from the SPI master.
- `spi_start`  out  1  frame enable to the SPI master (its CS is the inverse).
- `addr`  out  3  channel address sent in the current frame.
- `busy`  out  1  high whenever not in IDLE.
- `result_valid`  out  1  result held.
- `result_ready`  in  1  downstream accept.
- `result_data`  out  DATA_WIDTH  conversion value.
- `result_ch`  out  3  channel of `result_data`.
- `overflow`  out  1  sticky: an unaccepted result was overwritten.

## Operation
States: IDLE, FRAME, GAP.

**IDLE**
- On `scan_start` with `ch_enable` != 0: latch `continuous`, clear `overflow` and `prim` (the primer flag), select the first channel, go to FRAME.
- If `ch_enable` = 0, the start is ignored.

**Channel selection**
- Next enabled channel strictly after the current one, ascending, wrapping 7 -> 0.
- The first channel is the lowest enabled bit.
- `ch_enable` is sampled only at selection time, so mid-scan changes apply at the next selection.

**FRAME**
- `spi_start` = 1 and `addr` is stable for exactly FRAME_CYCLES cycles.
- Then record `prev_ch` <= `addr` and go to GAP.

**GAP**
- `spi_start` = 0 for GAP_CYCLES cycles.
- On the last gap cycle, `data_receive` is sampled.
  - If `prim` = 0: discard the sample (primer frame) and set `prim` = 1.
  - Otherwise: push {`data_receive`, channel addressed in the frame before the one just completed} to the output register.

**Address pipeline**
- The word returned in frame k belongs to the address sent in frame k-1.
- The sequencer keeps a one-deep channel history to tag results.

**Single pass with N enabled channels**
- N+1 frames are issued.
- The final frame re-sends the first enabled channel purely to flush the last result.
- After its gap: go to IDLE.

**Continuous**
- Loops indefinitely.
- `scan_stop` (may arrive in FRAME or GAP) is latched. The current frame and its gap capture complete, then the block goes to IDLE. No flush frame is issued, so the last addressed channel's result is dropped.

**Mask cleared mid-scan**
- If `ch_enable` = 0 at selection time, behave as stop.

**Output register**
- A push sets `result_valid`.
- `result_valid` clears on `result_valid && result_ready` unless a push occurs in the same cycle; push wins and `result_valid` stays 1.
- Push while valid and not ready: overwrite and set `overflow`.

## Timing
- All outputs are registered. Reset values: `spi_start` 0, `addr` 0, `busy` 0, `result_valid` 0, `result_data` 0, `result_ch` 0, `overflow` 0. State returns to IDLE.
- Reset mid-frame: `spi_start` is low the cycle after `sys_rst` is sampled.
- `scan_start` sampled at cycle t: `busy` and `spi_start` are 1 from t+1.
- Each frame is FRAME_CYCLES high followed by GAP_CYCLES low. Cycle from one `spi_start` rise to the next = FRAME_CYCLES + GAP_CYCLES.
- `result_valid` rises the cycle after the last gap cycle. It stays high until accepted or the next push.
- Single pass: `busy` falls the same cycle `result_valid` rises for the last result.
- Counters must hold FRAME_CYCLES without overflow (sized with $clog2). Channel index wraps modulo 8.

## Test plan
- Defaults, `ch_enable`=8'h05, single pass, `result_ready`=1, ADC model returns 12'h100+addr of the previous frame:
  - 3 frames with `addr` sequence 0, 2, 0.
  - Results (ch 0, 12'h100) then (ch 2, 12'h102).
  - `busy` low after 3*(1600+4) cycles.
- `ch_enable`=8'h80 with continuous: `addr` stays 7 every frame; results are ch 7. `scan_stop` mid-frame 5 -> IDLE after frame 5's gap, with exactly 4 results.
- `ch_enable`=0 with `scan_start` -> `busy` stays 0 and `spi_start` stays 0.
- `result_ready`=0, mask 8'h03, single pass:
  - Second push overwrites the first.
  - `overflow`=1 with `result_ch`=1.
  - Next `scan_start` clears `overflow`.
- `sys_rst` asserted mid-GAP of frame 2 -> all outputs at reset values next cycle, no push. A new `scan_start` rescans from the lowest enabled channel with a primer frame.
- Mask changed from 8'h0F to 8'h30 during frame with `addr`=1 -> the next `addr` is 4, then 5, wrapping back to 4.
